// File: rtl/rtc_seq_pkg.sv
// Shared types and constants for the RTC access sequencer: FSM states,
// control register values and the byte-index to RTC-address map.
package rtc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_LOCK   = 3'd1,
        S_WR_DATA   = 3'd2,
        S_WR_UNLOCK = 3'd3,
        S_RD_DATA   = 3'd4,
        S_PUBLISH   = 3'd5
    } seq_state_t;

    localparam logic [7:0] ADDR_CTRL = 8'h00;
    localparam logic [7:0] CTRL_LOCK = 8'h10;
    localparam logic [7:0] CTRL_RUN  = 8'h00;

    localparam logic [3:0] GRP0_FIRST = 4'd0;
    localparam logic [3:0] GRP0_LAST  = 4'd5;
    localparam logic [3:0] GRP1_FIRST = 4'd6;
    localparam logic [3:0] GRP1_LAST  = 4'd8;

    // Byte order: seg_C,min_C,hora_C,dia,mes,ano (clock/date), seg_T,min_T,hora_T (timer)
    function automatic logic [7:0] byte_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = ADDR_CTRL;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_seq_watchdog.sv
// Per-transaction bus timeout: counts cycles while a request is outstanding and
// flags expiry on the TIMEOUT_CYCLES-th cycle without an acknowledge.
module rtc_seq_watchdog
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expired
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || !i_active) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_expired = i_active && !i_ack && (r_cnt == 32'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rtc_access_sequencer.sv
// Arbitrates the RTC byte bus between edit commits (lock/write/unlock) and
// periodic 9-byte read-back. Optional bus timeout: define SEQ_TIMEOUT_EN.
module rtc_access_sequencer
    import rtc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_ref,
    input  logic        wr_req,
    input  logic        wr_sel,
    input  logic [71:0] wr_data,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic [71:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        err,
    output logic [2:0]  dbg_state
);

    seq_state_t  r_state;
    logic        r_wr_pend;
    logic        r_rd_pend;
    logic [71:0] r_wr_shadow;
    logic        r_sel_shadow;
    logic [71:0] r_wr_cur;
    logic        r_sel_cur;
    logic [3:0]  r_idx;
    logic [71:0] r_hold;
    logic        r_bus_req;
    logic        r_bus_wr;
    logic [7:0]  r_bus_addr;
    logic [7:0]  r_bus_wdata;
    logic [71:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_err;

    logic        w_timeout;
    logic [3:0]  w_last_idx;
    logic [7:0]  w_cur_byte;
    logic        w_txn_wr;
    logic [7:0]  w_txn_addr;
    logic [7:0]  w_txn_wdata;

`ifdef SEQ_TIMEOUT_EN
    rtc_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_active  (r_bus_req),
        .i_ack     (bus_ack),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    assign w_last_idx = r_sel_cur ? GRP1_LAST : GRP0_LAST;
    assign w_cur_byte = r_wr_cur[{r_idx, 3'b000} +: 8];

    // Transaction to issue in the current state once the bus is idle.
    always_comb begin
        w_txn_wr    = 1'b1;
        w_txn_addr  = ADDR_CTRL;
        w_txn_wdata = CTRL_RUN;
        case (r_state)
            S_WR_LOCK:   w_txn_wdata = CTRL_LOCK;
            S_WR_DATA: begin
                w_txn_addr  = byte_addr(r_idx);
                w_txn_wdata = w_cur_byte;
            end
            S_RD_DATA: begin
                w_txn_wr    = 1'b0;
                w_txn_addr  = byte_addr(r_idx);
                w_txn_wdata = 8'h00;
            end
            default: ;
        endcase
    end

    // Bus handshake: bus_req rises together with addr/wr/wdata, which hold until
    // the bus_ack cycle; bus_req falls the cycle after, leaving one idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_pend    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_wr_shadow  <= '0;
            r_sel_shadow <= 1'b0;
            r_wr_cur     <= '0;
            r_sel_cur    <= 1'b0;
            r_idx        <= '0;
            r_hold       <= '0;
            r_bus_req    <= 1'b0;
            r_bus_wr     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_wr_pend) begin
                        r_state   <= S_WR_LOCK;
                        r_wr_pend <= 1'b0;
                        r_wr_cur  <= r_wr_shadow;
                        r_sel_cur <= r_sel_shadow;
                        r_idx     <= r_sel_shadow ? GRP1_FIRST : GRP0_FIRST;
                    end else if (r_rd_pend) begin
                        r_state   <= S_RD_DATA;
                        r_rd_pend <= 1'b0;
                        r_idx     <= GRP0_FIRST;
                    end
                end
                S_WR_LOCK, S_WR_DATA, S_WR_UNLOCK, S_RD_DATA: begin
                    if (!r_bus_req) begin
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= w_txn_wr;
                        r_bus_addr  <= w_txn_addr;
                        r_bus_wdata <= w_txn_wdata;
                    end else if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        case (r_state)
                            S_WR_LOCK: r_state <= S_WR_DATA;
                            S_WR_DATA: begin
                                if (r_idx == w_last_idx) r_state <= S_WR_UNLOCK;
                                else                     r_idx   <= r_idx + 4'd1;
                            end
                            S_RD_DATA: begin
                                r_hold[{r_idx, 3'b000} +: 8] <= bus_rdata;
                                if (r_idx == GRP1_LAST) r_state <= S_PUBLISH;
                                else                    r_idx   <= r_idx + 4'd1;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end else if (w_timeout) begin
                        // Abandon the whole sequence; no unlock, nothing published.
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_PUBLISH: begin
                    r_rd_data  <= r_hold;
                    r_rd_valid <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Latched after the FSM so a new request in the start cycle stays pending.
            if (wr_req) begin
                r_wr_pend    <= 1'b1;
                r_wr_shadow  <= wr_data;
                r_sel_shadow <= wr_sel;
            end
            if (tick_ref) begin
                r_rd_pend <= 1'b1;
            end
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_wr    = r_bus_wr;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule
